// File: rtl/mean_square_acc_if.sv
// Sample-in / mean-square-out handshake bundle for mean_square_acc.
// A transfer happens on a rising edge where valid and ready are both high.
interface mean_square_acc_if #(
  parameter int DW = 4
);
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] out_data;
  logic            out_valid;
  logic            out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/mean_square_acc.sv
// Squares each unsigned sample with a DW-cycle shift-add multiplier and
// emits the truncated mean square of every block of 2**LOG2N samples.
module mean_square_acc #(
  parameter int DW    = 4,
  parameter int LOG2N = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  mean_square_acc_if.slave     bus,
  output logic                 busy,
  output logic [1:0]           state_dbg
);
  // Handshake: a sample is taken on an edge with in_valid && in_ready; a result
  // is consumed on an edge with out_valid && out_ready. clear overrides both.
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam int AW = 2*DW + LOG2N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state;
  logic [DW-1:0]     mcand;
  logic [DW-1:0]     mplier;
  logic [BW-1:0]     bitcnt;
  logic [2*DW-1:0]   partial;
  logic [AW-1:0]     acc;
  logic [LOG2N-1:0]  count;
  logic [2*DW-1:0]   out_data_q;
  logic              out_valid_q;

  logic [2*DW-1:0]   mcand_ext;
  logic [2*DW-1:0]   add_term;
  logic [2*DW-1:0]   partial_next;
  logic [AW-1:0]     acc_sum;
  logic              last_bit;

  always_comb begin
    mcand_ext    = {{DW{1'b0}}, mcand};
    add_term     = mplier[bitcnt] ? (mcand_ext << bitcnt) : '0;
    partial_next = partial + add_term;
    acc_sum      = acc + {{LOG2N{1'b0}}, partial_next};
    last_bit     = (bitcnt == BW'(DW - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mcand       <= '0;
      mplier      <= '0;
      bitcnt      <= '0;
      partial     <= '0;
      acc         <= '0;
      count       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      // out_data_q is left alone: a discarded result stays visible but invalid.
      state       <= IDLE;
      bitcnt      <= '0;
      partial     <= '0;
      acc         <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand   <= bus.in_data;
            mplier  <= bus.in_data;
            partial <= '0;
            bitcnt  <= '0;
            state   <= MUL;
          end
        end
        MUL: begin
          partial <= partial_next;
          bitcnt  <= bitcnt + BW'(1);
          if (last_bit) begin
            bitcnt <= '0;
            if (&count) begin
              // Dropping the low LOG2N bits is the divide by N.
              out_data_q  <= acc_sum[AW-1:LOG2N];
              out_valid_q <= 1'b1;
              acc         <= '0;
              count       <= '0;
              state       <= HOLD;
            end else begin
              acc   <= acc_sum;
              count <= count + LOG2N'(1);
              state <= IDLE;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = (state == MUL);
  assign state_dbg     = state;
endmodule

// File: tb/tb_mean_square_acc.sv
// Directed bench for mean_square_acc (DW=4, LOG2N=2) with hand-computed
// mean-square results held in an expected queue.
module tb_mean_square_acc;
  localparam int DW = 4;
  localparam int W  = 2*DW;

  logic clk;
  logic rst_n;
  logic clear;
  logic busy;
  logic [1:0] state_dbg;
  int cyc;
  int n_tests;
  int n_fail;
  logic [W-1:0] exp_q[$];

  mean_square_acc_if #(.DW(DW)) bus ();

  mean_square_acc #(.DW(DW), .LOG2N(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .bus       (bus.slave),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  // Presents v until accepted; acc_cyc is the cycle count right after the accepting edge.
  task automatic send_sample(input logic [DW-1:0] v, input bit keep_valid,
                             output bit ok, output int acc_cyc);
    ok = 1'b0;
    acc_cyc = 0;
    bus.in_data  = v;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (ok) begin
      step();
      acc_cyc = cyc;
    end
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  task automatic wait_output(output bit ok, output int seen_cyc);
    ok = 1'b0;
    seen_cyc = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        seen_cyc = cyc;
        break;
      end
      step();
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic send_block(input logic [DW-1:0] a, b, c, d, output bit ok);
    bit o;
    int ac;
    logic [DW-1:0] v[4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_sample(v[i], 1'b0, o, ac);
      ok = ok & o;
    end
  endtask

  // Waits for a result, checks it against the queue head, then consumes it.
  task automatic check_result(input string name);
    bit ok;
    int sc;
    logic [W-1:0] exp;
    exp = exp_q.pop_front();
    wait_output(ok, sc);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: out_valid never rose, required out_data=%0d", name, exp);
    end else if (bus.out_data !== exp) begin
      n_fail++;
      $display("FAIL %s: out_data=%0d required %0d", name, bus.out_data, exp);
    end
    if (ok) consume();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    n_tests++;
    if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %0d required 0", bus.out_data); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    int ac[4];
    bit ok[4];
    bit wok;
    int sc;
    for (int i = 0; i < 4; i++) send_sample(DW'(i + 1), (i < 3), ok[i], ac[i]);
    n_tests++;
    if (!(ok[0] && ok[1] && ok[2] && ok[3])) begin
      n_fail++; $display("FAIL b2b_accept: accepted=%b%b%b%b required 1111", ok[0], ok[1], ok[2], ok[3]);
    end
    for (int i = 1; i < 4; i++) begin
      n_tests++;
      if (ac[i] - ac[i-1] !== DW + 1) begin
        n_fail++; $display("FAIL b2b_gap%0d: gap=%0d required %0d", i, ac[i] - ac[i-1], DW + 1);
      end
    end
    n_tests++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_busy: busy=%b in_ready=%b required 1,0", busy, bus.in_ready);
    end
    wait_output(wok, sc);
    n_tests++;
    if (!wok || sc - ac[3] !== DW) begin
      n_fail++; $display("FAIL b2b_out_latency: seen=%0d after accept, required %0d", sc - ac[3], DW);
    end
    exp_q.push_back(W'(7));
    check_result("b2b_mean");
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_after_take: out_valid=%b in_ready=%b required 0,1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_max();
    bit ok;
    send_block(4'd15, 4'd15, 4'd15, 4'd15, ok);
    exp_q.push_back(W'(225));
    check_result("max_mean");
  endtask

  task automatic test_hold_stall();
    bit ok;
    int sc;
    bit stable;
    send_block(4'd0, 4'd0, 4'd0, 4'd3, ok);
    wait_output(ok, sc);
    stable = ok;
    bus.in_data  = 4'd9;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid !== 1'b1 || bus.out_data !== W'(2) || bus.in_ready !== 1'b0) stable = 1'b0;
      step();
    end
    n_tests++;
    if (!stable) begin
      n_fail++; $display("FAIL hold_stall: out_valid=%b out_data=%0d in_ready=%b required 1,2,0", bus.out_valid, bus.out_data, bus.in_ready);
    end
    consume();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: out_valid=%b in_ready=%b busy=%b required 0,1,0", bus.out_valid, bus.in_ready, busy);
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_clear_partial();
    bit ok;
    int ac;
    send_sample(4'd8, 1'b0, ok, ac);
    send_sample(4'd8, 1'b0, ok, ac);
    for (int i = 0; i < 20 && !bus.in_ready; i++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    send_block(4'd4, 4'd4, 4'd4, 4'd4, ok);
    exp_q.push_back(W'(16));
    check_result("clear_partial_mean");
  endtask

  task automatic test_reset_mid_mul();
    bit ok;
    int ac;
    send_sample(4'd9, 1'b0, ok, ac);
    send_sample(4'd9, 1'b0, ok, ac);
    send_sample(4'd9, 1'b0, ok, ac);
    step();
    rst_n = 1'b0;
    step();
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_data !== '0) begin
      n_fail++; $display("FAIL rst_mid_mul: in_ready=%b out_valid=%b busy=%b out_data=%0d required 1,0,0,0", bus.in_ready, bus.out_valid, busy, bus.out_data);
    end
    rst_n = 1'b1;
    send_sample(4'd5, 1'b0, ok, ac);
    send_sample(4'd5, 1'b0, ok, ac);
    send_sample(4'd5, 1'b0, ok, ac);
    for (int i = 0; i < DW + 2; i++) step();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_spurious: out_valid=%b after 3 samples required 0", bus.out_valid);
    end
    send_sample(4'd5, 1'b0, ok, ac);
    exp_q.push_back(W'(25));
    check_result("rst_mean");
  endtask

  task automatic test_clear_priority();
    bit ok;
    int sc;
    send_block(4'd1, 4'd1, 4'd1, 4'd1, ok);
    wait_output(ok, sc);
    bus.out_ready = 1'b1;
    clear = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== W'(1)) begin
      n_fail++; $display("FAIL clr_vs_out_ready: out_valid=%b in_ready=%b out_data=%0d required 0,1,1", bus.out_valid, bus.in_ready, bus.out_data);
    end
    bus.in_data  = 4'd7;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    clear = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL clr_vs_accept: busy=%b in_ready=%b required 0,1", busy, bus.in_ready);
    end
    send_block(4'd2, 4'd2, 4'd2, 4'd2, ok);
    exp_q.push_back(W'(4));
    check_result("clr_count_zero_mean");
  endtask

  // ---------------- main ----------------
  initial begin
    cyc = 0;
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    step();
    test_reset();
    test_back_to_back();
    test_max();
    test_hold_stall();
    test_clear_partial();
    test_reset_mid_mul();
    test_clear_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
